// File: rtl/fmap_pkg.sv
// Shared constants and types for the feature-map write-back block.
package fmap_pkg;

   localparam int unsigned WDP        = 16;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fmap_writer_if.sv
// Result-beat input, RAM write port and frame status of fmap_writer.
interface fmap_writer_if #(
   parameter int unsigned OUTPUT_NUM = 6,
   parameter int unsigned WDP        = fmap_pkg::WDP
);

   logic                      go;
   logic                      q_en;
   logic [WDP*OUTPUT_NUM-1:0] q;
   logic [15:0]               ab;
   logic [WDP-1:0]            db;
   logic                      cenb;
   logic                      wenb;
   logic                      busy;
   logic                      ready;
   logic                      ovf;

   modport master (
      output go, q_en, q,
      input  ab, db, cenb, wenb, busy, ready, ovf
   );

   modport slave (
      input  go, q_en, q,
      output ab, db, cenb, wenb, busy, ready, ovf
   );

endinterface

// File: rtl/fmap_wr_fifo.sv
// Two-entry beat FIFO; a push into a full FIFO is legal when a pop happens in the same cycle.
module fmap_wr_fifo
   import fmap_pkg::*;
#(
   parameter int unsigned DW = 96
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DW-1:0]         din,
   output logic [DW-1:0]         dout,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [DW-1:0]         mem_q [FIFO_DEPTH];
   logic [DW-1:0]         mem_d [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_q, wr_d;
   logic [FIFO_PTR_W-1:0] rd_q, rd_d;
   logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
         end
         if (pop) begin
            rd_d = rd_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/fmap_writer.sv
// Serialises result beats into plane-major single-port RAM writes, one lane per cycle.
// Optional FMAP_WR_RELU_EN: lanes with the sign bit set are written as zero.
module fmap_writer #(
   parameter int unsigned OUTPUT_NUM = 6,
   parameter int unsigned OUT_WIDTH  = 28,
   parameter int unsigned OUT_HEIGHT = 28,
   parameter int unsigned WDP        = fmap_pkg::WDP
) (
   input  logic          clk,
   input  logic          rstn,
   fmap_writer_if.slave  bus
);

   import fmap_pkg::*;

   localparam int unsigned BEAT_W = WDP * OUTPUT_NUM;
   localparam int unsigned PLANE  = OUT_WIDTH * OUT_HEIGHT;
   localparam int unsigned LANE_W = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
   localparam int unsigned COL_W  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam int unsigned ROW_W  = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
   localparam int unsigned BASE_W = (PLANE > 1) ? $clog2(PLANE) : 1;
   localparam int unsigned ACC_W  = $clog2(PLANE + 1);

   state_t                state_q, state_d;
   logic [15:0]           ab_q, ab_d;
   logic [WDP-1:0]        db_q, db_d;
   logic                  cenb_q, cenb_d;
   logic                  wenb_q, wenb_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  ovf_q, ovf_d;
   logic                  active_q, active_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [BASE_W-1:0]     base_q, base_d;
   logic                  last_q, last_d;
   logic [ACC_W-1:0]      acc_q, acc_d;

   logic                  push, pop, flush, last_lane;
   logic [LANE_W-1:0]     lane_nx;
   logic [BASE_W-1:0]     base_new;
   logic [BEAT_W-1:0]     fifo_head;
   logic [FIFO_CNT_W-1:0] fifo_cnt;

   fmap_wr_fifo #(.DW(BEAT_W)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (bus.q),
      .dout  (fifo_head),
      .count (fifo_cnt)
   );

   // Lane 0 sits in the most-significant WDP bits of a beat.
   function automatic logic [WDP-1:0] lane_val(input logic [BEAT_W-1:0] b,
                                                input logic [LANE_W-1:0] l);
      logic [WDP-1:0] v;
      v = WDP'(b >> ((OUTPUT_NUM - 1 - 32'(l)) * WDP));
`ifdef FMAP_WR_RELU_EN
      if (v[WDP-1]) v = '0;
`endif
      return v;
   endfunction

   function automatic logic [15:0] lane_addr(input logic [LANE_W-1:0] l,
                                             input logic [BASE_W-1:0] b);
      return 16'(32'(l) * PLANE + 32'(b));
   endfunction

   assign last_lane = active_q && (lane_q == LANE_W'(OUTPUT_NUM - 1));
   assign lane_nx   = lane_q + 1'b1;
   assign base_new  = BASE_W'(32'(row_q) * OUT_WIDTH + 32'(col_q));

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ab_d     = ab_q;
      db_d     = db_q;
      cenb_d   = 1'b1;
      wenb_d   = 1'b1;
      ovf_d    = ovf_q;
      active_d = active_q;
      lane_d   = lane_q;
      beat_d   = beat_q;
      col_d    = col_q;
      row_d    = row_q;
      base_d   = base_q;
      last_d   = last_q;
      acc_d    = acc_q;
      push     = 1'b0;
      pop      = 1'b0;
      flush    = 1'b0;

      case (state_q)
         IDLE: state_d = IDLE;
         RUN: begin
            pop = (fifo_cnt != '0) && (!active_q || last_lane);
            if (bus.q_en) begin
               if ((acc_q < ACC_W'(PLANE)) &&
                   ((fifo_cnt < FIFO_CNT_W'(FIFO_DEPTH)) || pop)) begin
                  push  = 1'b1;
                  acc_d = acc_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (pop) begin
               beat_d   = fifo_head;
               active_d = 1'b1;
               lane_d   = '0;
               base_d   = base_new;
               last_d   = (row_q == ROW_W'(OUT_HEIGHT - 1)) && (col_q == COL_W'(OUT_WIDTH - 1));
               ab_d     = lane_addr('0, base_new);
               db_d     = lane_val(fifo_head, '0);
               cenb_d   = 1'b0;
               wenb_d   = 1'b0;
               if (col_q == COL_W'(OUT_WIDTH - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end else if (active_q && !last_lane) begin
               lane_d = lane_nx;
               ab_d   = lane_addr(lane_nx, base_q);
               db_d   = lane_val(beat_q, lane_nx);
               cenb_d = 1'b0;
               wenb_d = 1'b0;
            end else if (last_lane) begin
               active_d = 1'b0;
               if (last_q) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A restart wins over everything, including a beat in the same cycle.
      if (bus.go) begin
         state_d  = RUN;
         flush    = 1'b1;
         push     = 1'b0;
         pop      = 1'b0;
         ovf_d    = 1'b0;
         acc_d    = '0;
         col_d    = '0;
         row_d    = '0;
         lane_d   = '0;
         active_d = 1'b0;
         last_d   = 1'b0;
         ab_d     = ab_q;
         db_d     = db_q;
         cenb_d   = 1'b1;
         wenb_d   = 1'b1;
      end

      busy_d  = (state_d != IDLE);
      ready_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ab_q     <= '0;
         db_q     <= '0;
         cenb_q   <= 1'b1;
         wenb_q   <= 1'b1;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
         active_q <= 1'b0;
         lane_q   <= '0;
         beat_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
         base_q   <= '0;
         last_q   <= 1'b0;
         acc_q    <= '0;
      end else begin
         ab_q     <= ab_d;
         db_q     <= db_d;
         cenb_q   <= cenb_d;
         wenb_q   <= wenb_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         ovf_q    <= ovf_d;
         active_q <= active_d;
         lane_q   <= lane_d;
         beat_q   <= beat_d;
         col_q    <= col_d;
         row_q    <= row_d;
         base_q   <= base_d;
         last_q   <= last_d;
         acc_q    <= acc_d;
      end
   end

   assign bus.ab    = ab_q;
   assign bus.db    = db_q;
   assign bus.cenb  = cenb_q;
   assign bus.wenb  = wenb_q;
   assign bus.busy  = busy_q;
   assign bus.ready = ready_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Cycle-by-cycle check of fmap_writer against a write-schedule model (2 lanes, 3x2 planes).
module tb_fmap_writer;

   localparam int unsigned N  = 2;
   localparam int unsigned W  = 3;
   localparam int unsigned H  = 2;
   localparam int unsigned DW = 16;
   localparam int          P  = int'(W * H);

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fmap_writer_if #(.OUTPUT_NUM(N), .WDP(DW)) bus ();

   fmap_writer #(.OUTPUT_NUM(N), .OUT_WIDTH(W), .OUT_HEIGHT(H), .WDP(DW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;

   // Model: every accepted beat is turned into scheduled writes keyed by clock edge.
   int m_ab[int];
   int m_db[int];
   int m_push[$];
   int m_pop[$];
   int m_last_ab, m_last_db, m_done, m_acc, m_prev_pop;
   bit m_run, m_ovf;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, act, exp);
      end
   endtask

   task automatic model_step(input int c, input logic r, input logic g, input logic qe,
                             input logic [N*DW-1:0] qd);
      int cnt, pe, lane;
      bit popnow;
      if (!r) begin
         m_ab.delete(); m_db.delete();
         m_run = 0; m_done = -1; m_ovf = 0; m_last_ab = 0; m_last_db = 0;
      end else if (g) begin
         m_ab.delete(); m_db.delete(); m_push.delete(); m_pop.delete();
         m_run = 1; m_done = -1; m_acc = 0; m_prev_pop = -1000; m_ovf = 0;
      end else if (qe && m_run && (m_done < 0 || c <= m_done)) begin
         cnt = 0; popnow = 0;
         foreach (m_push[i]) begin
            if (m_push[i] < c && c <= m_pop[i]) cnt++;
            if (m_pop[i] == c) popnow = 1;
         end
         if (m_acc < P && (cnt < 2 || (cnt == 2 && popnow))) begin
            pe = (c + 1 > m_prev_pop + int'(N)) ? c + 1 : m_prev_pop + int'(N);
            m_push.push_back(c); m_pop.push_back(pe); m_prev_pop = pe;
            for (int i = 0; i < int'(N); i++) begin
               lane = int'((qd >> ((int'(N) - 1 - i) * int'(DW))) & 32'hFFFF);
`ifdef FMAP_WR_RELU_EN
               if (lane >= 32'h8000) lane = 0;
`endif
               m_ab[pe + i] = (i * P + m_acc) & 32'hFFFF;
               m_db[pe + i] = lane;
            end
            if (m_acc == P - 1) m_done = pe + int'(N);
            m_acc++;
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic g, input logic qe, input logic [N*DW-1:0] qd);
      bit wr;
      @(negedge clk);
      rstn = r; bus.go = g; bus.q_en = qe; bus.q = qd;
      @(posedge clk);
      edge_n++;
      model_step(edge_n, r, g, qe, qd);
      wr = m_ab.exists(edge_n);
      if (wr) begin
         m_last_ab = m_ab[edge_n];
         m_last_db = m_db[edge_n];
      end
      #1;
      check_eq("cenb", 32'(bus.cenb), wr ? 0 : 1);
      check_eq("wenb", 32'(bus.wenb), wr ? 0 : 1);
      check_eq("ab", 32'(bus.ab), 32'(m_last_ab));
      check_eq("db", 32'(bus.db), 32'(m_last_db));
      check_eq("busy", 32'(bus.busy), (m_run && (m_done < 0 || edge_n <= m_done)) ? 1 : 0);
      check_eq("ready", 32'(bus.ready), (edge_n == m_done) ? 1 : 0);
      check_eq("ovf", 32'(bus.ovf), 32'(m_ovf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0);
   endtask

   initial begin
      int dens;
      logic r, g, qe;
      rstn = 1'b0; bus.go = 1'b0; bus.q_en = 1'b0; bus.q = '0;
      m_done = -1; m_run = 0; m_ovf = 0; m_last_ab = 0; m_last_db = 0;
      m_acc = 0; m_prev_pop = -1000;

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
      // Beats while idle are ignored.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'h1234_5678);
      // Single beat: lane 0 at ab=0, lane 1 at ab=6.
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 32'h0005_FFFE);
      idle(6);
      // Full frame with spacing 4.
      cyc(1'b1, 1'b1, 1'b0, '0);
      for (int p = 0; p < P; p++) begin
         cyc(1'b1, 1'b0, 1'b1, {16'(p), 16'(p + 32'h100)});
         idle(3);
      end
      idle(4);
      // Five back-to-back beats, overflow, then restart mid-frame.
      cyc(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, {16'(i + 32'h10), 16'(i + 32'h8020)});
      idle(6);
      cyc(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
      cyc(1'b1, 1'b0, 1'b1, 32'h0042_0043);
      idle(4);
      // Seven beats into a six-pixel frame.
      cyc(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, 1'b1, $urandom);
         cyc(1'b1, 1'b0, 1'b0, '0);
      end
      idle(4);
      // Reset in the middle of a burst, then beats with no new go.
      cyc(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, $urandom);
      cyc(1'b0, 1'b0, 1'b1, $urandom);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, $urandom);
      idle(3);
      // Randomized frames with sporadic restarts and resets.
      for (int f = 0; f < 30; f++) begin
         dens = int'($urandom_range(0, 3));
         cyc(1'b1, 1'b1, 1'b0, '0);
         for (int k = 0; k < 40; k++) begin
            r  = ($urandom_range(0, 149) != 0);
            g  = ($urandom_range(0, 79) == 0);
            qe = ($urandom_range(0, dens) == 0);
            cyc(r, g, qe, $urandom);
         end
      end
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
